lsu_sequencer: RTL and testbench
================================

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, max wait cycles for dmem_ready.
REQ-003 clk  input  1  system clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 issue_valid  input  1  decoded memory instruction present.
REQ-006 mem_rw  input  1  1 = store, 0 = load.
REQ-007 type_sel  input  3  funct3 access type.
REQ-008 addr  input  DWIDTH  effective address from ALU.
REQ-009 wdata  input  DWIDTH  store data from rs2.
REQ-010 dmem_req  output  1  memory request valid.
REQ-011 dmem_we  output  1  write enable.
REQ-012 dmem_addr  output  DWIDTH  doubleword-aligned address (addr[2:0] zeroed).
REQ-013 dmem_wdata  output  DWIDTH  lane-shifted store data.
REQ-014 dmem_be  output  DWIDTH/8  byte enables.
REQ-015 dmem_ready  input  1  memory accepts request / returns data.
REQ-016 dmem_rdata  input  DWIDTH  read data.
REQ-017 stall  output  1  holds PC and pipeline.
REQ-018 load_data  output  DWIDTH  extended load result for WBSel=0.
REQ-019 load_valid  output  1  one-cycle writeback strobe.
REQ-020 exc  output  1  one-cycle exception pulse.
REQ-021 exc_code  output  2  0 misaligned, 1 illegal type, 2 timeout.

Function
REQ-022 States SHALL be IDLE, REQ, DONE, ERR; single-cycle default transitions only as stated.
REQ-023 IDLE: issue_valid with legal, aligned access SHALL go to REQ next cycle, latching mem_rw, type_sel, addr, wdata.
REQ-024 Alignment SHALL require addr[0]=0 for size 1, addr[1:0]=0 for size 2, addr[2:0]=0 for size 3 (size = type_sel[1:0]).
REQ-025 Legal type_sel: loads 0-6; stores 0-3; else IDLE->ERR with exc_code=1, no dmem_req.
REQ-026 Misaligned access SHALL go IDLE->ERR with exc_code=0; illegal takes priority over misaligned.
REQ-027 REQ: dmem_req SHALL stay high with stable address/data/be until a cycle with dmem_ready=1, then go to DONE.
REQ-028 Wait counter SHALL clear on entering REQ, increment each REQ cycle without ready; reaching TIMEOUT SHALL go to ERR with exc_code=2; ready on the same cycle wins.
REQ-029 Load: dmem_rdata SHALL be captured on the ready cycle, shifted by addr[2:0] bytes, sign-extended (type_sel[2]=0) or zero-extended (type_sel[2]=1).
REQ-030 DONE: load_valid SHALL pulse for loads only; return to IDLE next cycle.
REQ-031 ERR: exc SHALL pulse one cycle; return to IDLE; no writeback.
REQ-032 Store: dmem_be SHALL be (1<<(1<<size))-1 shifted left by addr[2:0]; wdata shifted left by 8*addr[2:0].
REQ-033 stall SHALL be combinationally high in IDLE when issue_valid, and high in REQ; low in DONE and ERR.
REQ-034 issue_valid outside IDLE SHALL be ignored.
REQ-035 Minimum load latency SHALL be 2 cycles issue-to-load_valid (ready=1 in first REQ cycle).

Reset
REQ-036 rst_n low SHALL asynchronously force IDLE, counter 0, all outputs 0 (load_data 0, dmem_be 0).
REQ-037 Reset mid-REQ SHALL drop dmem_req immediately; no load_valid or exc follows.

Structure
REQ-038 State encoding, exc_code values and funct3 constants SHALL live in shared package rv_pkg.
REQ-039 Lane shifting, byte-enable generation and extension SHALL be sub-module lsu_align (combinational).

Verification
REQ-040 lw addr=0x1004, rdata=0x80000000_00000000, ready in first REQ -> load_valid 2 cycles after issue, load_data=0xFFFFFFFF_80000000.
REQ-041 sb addr=0x1003, wdata=0xAB -> dmem_be=0x08, dmem_wdata=0xAB000000, dmem_addr=0x1000, dmem_we=1.
REQ-042 ld addr=0x1004 -> no dmem_req, exc=1, exc_code=0, stall low after 1 cycle.
REQ-043 lbu with ready held low 255 cycles -> exc_code=2; ready on cycle 255 -> normal load_valid instead.
REQ-044 rst_n low during REQ with ready low -> dmem_req=0 same cycle, IDLE after release, no strobes.
REQ-045 store type_sel=4 -> exc_code=1; subsequent back-to-back lhu addr=0x2 rdata=0xFFFF0000 -> load_data=0xFFFF.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared LSU types: sequencer states, exception codes, funct3 access types.
// Also holds the legality and alignment predicates used at issue time.
package rv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } lsu_state_t;

   localparam logic [1:0] EXC_MISALIGN = 2'd0;
   localparam logic [1:0] EXC_ILLEGAL  = 2'd1;
   localparam logic [1:0] EXC_TIMEOUT  = 2'd2;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_D  = 3'd3;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;
   localparam logic [2:0] F3_WU = 3'd6;

   // Stores have no unsigned variants; loads allow everything except funct3=7.
   function automatic logic type_legal(input logic rw, input logic [2:0] f3);
      logic ok;
      ok = rw ? (f3 <= F3_D) : (f3 <= F3_WU);
      return ok;
   endfunction

   function automatic logic addr_aligned(input logic [2:0] f3, input logic [2:0] lo);
      logic ok;
      case (f3[1:0])
         2'd0:    ok = 1'b1;
         2'd1:    ok = (lo[0] == 1'b0);
         2'd2:    ok = (lo[1:0] == 2'b00);
         default: ok = (lo == 3'b000);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane aligner: store byte enables and data shift, load shift and sign/zero extension.
// Purely combinational, zero latency, no flow control.
module lsu_align #(
   parameter int DWIDTH = 64
) (
   input  logic [2:0]          type_sel,
   input  logic [2:0]          offset,
   input  logic [DWIDTH-1:0]   wdata,
   input  logic [DWIDTH-1:0]   rdata,
   output logic [DWIDTH/8-1:0] be,
   output logic [DWIDTH-1:0]   wdata_sh,
   output logic [DWIDTH-1:0]   load_data
);

   localparam int NB = DWIDTH / 8;

   logic [DWIDTH-1:0] rdata_sh;
   logic              sign;
   int                nbytes;
   int                nbits;

   always_comb begin
      nbytes = 1 << type_sel[1:0];
      nbits  = 8 * nbytes;
      if (nbits > DWIDTH) nbits = DWIDTH;

      be = '0;
      for (int i = 0; i < NB; i++) begin
         if (i < nbytes) be[i] = 1'b1;
      end
      be = be << offset;

      wdata_sh = wdata << {offset, 3'b000};
      rdata_sh = rdata >> {offset, 3'b000};

      // type_sel[2] selects the unsigned load variants.
      sign = ~type_sel[2] & rdata_sh[nbits-1];
      for (int i = 0; i < DWIDTH; i++) begin
         load_data[i] = (i < nbits) ? rdata_sh[i] : sign;
      end
   end

endmodule

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: issue check, single outstanding dmem request, writeback or exception pulse.
// Load latency 2 cycles min; waits on dmem_ready up to TIMEOUT cycles while holding stall.
module lsu_sequencer
   import rv_pkg::*;
#(
   parameter int DWIDTH  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue_valid,
   input  logic                mem_rw,
   input  logic [2:0]          type_sel,
   input  logic [DWIDTH-1:0]   addr,
   input  logic [DWIDTH-1:0]   wdata,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [DWIDTH-1:0]   dmem_addr,
   output logic [DWIDTH-1:0]   dmem_wdata,
   output logic [DWIDTH/8-1:0] dmem_be,
   input  logic                dmem_ready,
   input  logic [DWIDTH-1:0]   dmem_rdata,
   output logic                stall,
   output logic [DWIDTH-1:0]   load_data,
   output logic                load_valid,
   output logic                exc,
   output logic [1:0]          exc_code
);

   localparam int CW = $clog2(TIMEOUT + 1);

   lsu_state_t        state;
   logic [CW-1:0]     wait_cnt;
   logic              rw_q;
   logic [2:0]        type_q;
   logic [2:0]        off_q;
   logic [DWIDTH-1:0] wdata_q;

   logic              legal;
   logic              aligned;
   logic [2:0]        al_type;
   logic [2:0]        al_off;
   logic [DWIDTH-1:0] al_wdata;
   logic [DWIDTH/8-1:0] al_be;
   logic [DWIDTH-1:0] al_wdata_sh;
   logic [DWIDTH-1:0] al_load;

   assign legal   = type_legal(mem_rw, type_sel);
   assign aligned = addr_aligned(type_sel, addr[2:0]);

   // In IDLE the aligner sees the incoming instruction so the request can be registered;
   // afterwards it sees the latched one while dmem_rdata arrives.
   assign al_type  = (state == ST_IDLE) ? type_sel  : type_q;
   assign al_off   = (state == ST_IDLE) ? addr[2:0] : off_q;
   assign al_wdata = (state == ST_IDLE) ? wdata     : wdata_q;

   lsu_align #(.DWIDTH(DWIDTH)) u_align (
      .type_sel  (al_type),
      .offset    (al_off),
      .wdata     (al_wdata),
      .rdata     (dmem_rdata),
      .be        (al_be),
      .wdata_sh  (al_wdata_sh),
      .load_data (al_load)
   );

   assign stall = rst_n & (((state == ST_IDLE) & issue_valid) | (state == ST_REQ));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         rw_q       <= 1'b0;
         type_q     <= 3'd0;
         off_q      <= 3'd0;
         wdata_q    <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= '0;
         load_data  <= '0;
         load_valid <= 1'b0;
         exc        <= 1'b0;
         exc_code   <= 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (issue_valid) begin
                  if (!legal) begin
                     state    <= ST_ERR;
                     exc      <= 1'b1;
                     exc_code <= EXC_ILLEGAL;
                  end else if (!aligned) begin
                     state    <= ST_ERR;
                     exc      <= 1'b1;
                     exc_code <= EXC_MISALIGN;
                  end else begin
                     state      <= ST_REQ;
                     wait_cnt   <= '0;
                     rw_q       <= mem_rw;
                     type_q     <= type_sel;
                     off_q      <= addr[2:0];
                     wdata_q    <= wdata;
                     dmem_req   <= 1'b1;
                     dmem_we    <= mem_rw;
                     dmem_addr  <= {addr[DWIDTH-1:3], 3'b000};
                     dmem_wdata <= al_wdata_sh;
                     dmem_be    <= al_be;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_ready) begin
                  state    <= ST_DONE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  dmem_be  <= '0;
                  if (!rw_q) begin
                     load_data  <= al_load;
                     load_valid <= 1'b1;
                  end
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  state    <= ST_ERR;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  dmem_be  <= '0;
                  exc      <= 1'b1;
                  exc_code <= EXC_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            ST_DONE: begin
               load_valid <= 1'b0;
               state      <= ST_IDLE;
            end
            ST_ERR: begin
               exc   <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Randomized and directed bench for lsu_sequencer against a transaction-level reference model.
module tb_lsu_sequencer;

   localparam int DW = 64;
   localparam int TO = 255;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          issue_valid;
   logic          mem_rw;
   logic [2:0]    type_sel;
   logic [DW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          dmem_req;
   logic          dmem_we;
   logic [DW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata;
   logic [7:0]    dmem_be;
   logic          dmem_ready;
   logic [DW-1:0] dmem_rdata;
   logic          stall;
   logic [DW-1:0] load_data;
   logic          load_valid;
   logic          exc;
   logic [1:0]    exc_code;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]    cap_be;
   logic [DW-1:0] cap_wdata;
   logic [DW-1:0] cap_addr;
   logic          cap_we;

   lsu_sequencer #(.DWIDTH(DW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .mem_rw      (mem_rw),
      .type_sel    (type_sel),
      .addr        (addr),
      .wdata       (wdata),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_be     (dmem_be),
      .dmem_ready  (dmem_ready),
      .dmem_rdata  (dmem_rdata),
      .stall       (stall),
      .load_data   (load_data),
      .load_valid  (load_valid),
      .exc         (exc),
      .exc_code    (exc_code)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] m_be(input logic [2:0] f3, input logic [2:0] off);
      int n;
      n = 1 << f3[1:0];
      return 8'(((1 << n) - 1) << off);
   endfunction

   function automatic logic [63:0] m_wdata(input logic [2:0] off, input logic [63:0] wd);
      return wd << (8 * off);
   endfunction

   function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [2:0] off,
                                          input logic [63:0] rd);
      logic [63:0] v;
      logic [63:0] mask;
      int n;
      v = rd >> (8 * off);
      n = 8 << f3[1:0];
      if (n < 64) begin
         mask = (64'd1 << n) - 64'd1;
         if (!f3[2] && v[n-1]) v = v | ~mask;
         else                  v = v & mask;
      end
      return v;
   endfunction

   // One complete transaction from an IDLE cycle back to IDLE; n_low = REQ cycles without ready.
   task automatic run_txn(input logic rw, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] rd,
                          input int n_low, input bit junk);
      bit ill, mis;
      logic [63:0] ea;
      ill = rw ? (f3 > 3'd3) : (f3 == 3'd7);
      mis = (a % (64'd1 << f3[1:0])) != 0;
      ea  = a & ~64'h7;
      issue_valid = 1'b1; mem_rw = rw; type_sel = f3; addr = a; wdata = wd; dmem_ready = 1'b0;
      #1;
      vectors++;
      if (stall !== 1'b1) begin
         miscompares++; $display("FAIL stall_issue: got %b want 1", stall);
      end
      @(posedge clk); #1;
      issue_valid = 1'b0;
      if (ill || mis) begin
         vectors++;
         if (exc !== 1'b1 || exc_code !== (ill ? 2'd1 : 2'd0) || dmem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL err_entry: exc=%b code=%0d req=%b want exc=1 code=%0d req=0",
                     exc, exc_code, dmem_req, ill ? 1 : 0);
         end
         vectors++;
         if (stall !== 1'b0) begin
            miscompares++; $display("FAIL stall_err: got %b want 0", stall);
         end
         @(posedge clk); #1;
         vectors++;
         if (exc !== 1'b0 || load_valid !== 1'b0) begin
            miscompares++; $display("FAIL err_exit: exc=%b lv=%b want 0 0", exc, load_valid);
         end
         return;
      end
      cap_be = dmem_be; cap_wdata = dmem_wdata; cap_addr = dmem_addr; cap_we = dmem_we;
      vectors++;
      if (dmem_req !== 1'b1 || dmem_we !== rw || dmem_addr !== ea) begin
         miscompares++;
         $display("FAIL req_issue: req=%b we=%b addr=%h want 1 %b %h", dmem_req, dmem_we, dmem_addr, rw, ea);
      end
      vectors++;
      if (dmem_be !== m_be(f3, a[2:0])) begin
         miscompares++; $display("FAIL req_be: got %h want %h", dmem_be, m_be(f3, a[2:0]));
      end
      if (rw) begin
         vectors++;
         if (dmem_wdata !== m_wdata(a[2:0], wd)) begin
            miscompares++;
            $display("FAIL req_wdata: got %h want %h", dmem_wdata, m_wdata(a[2:0], wd));
         end
      end
      for (int c = 0; c < TO; c++) begin
         if (junk) begin
            issue_valid = 1'b1; mem_rw = 1'($urandom); type_sel = 3'($urandom);
            addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
         end
         dmem_ready = (c == n_low);
         dmem_rdata = (c == n_low) ? rd : {$urandom, $urandom};
         #1;
         vectors++;
         if (dmem_req !== 1'b1 || stall !== 1'b1 || dmem_addr !== ea || dmem_be !== cap_be
             || dmem_wdata !== cap_wdata) begin
            miscompares++;
            $display("FAIL req_hold: cycle %0d req=%b stall=%b addr=%h be=%h want 1 1 %h %h",
                     c, dmem_req, stall, dmem_addr, dmem_be, ea, cap_be);
         end
         @(posedge clk); #1;
         if (c == n_low) break;
      end
      issue_valid = 1'b0; dmem_ready = 1'b0;
      if (n_low < TO) begin
         vectors++;
         if (load_valid !== !rw || dmem_req !== 1'b0 || stall !== 1'b0 || exc !== 1'b0) begin
            miscompares++;
            $display("FAIL done: lv=%b req=%b stall=%b exc=%b want %b 0 0 0",
                     load_valid, dmem_req, stall, exc, !rw);
         end
         if (!rw) begin
            vectors++;
            if (load_data !== m_load(f3, a[2:0], rd)) begin
               miscompares++;
               $display("FAIL load_data: got %h want %h", load_data, m_load(f3, a[2:0], rd));
            end
         end
      end else begin
         vectors++;
         if (exc !== 1'b1 || exc_code !== 2'd2 || dmem_req !== 1'b0 || load_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: exc=%b code=%0d req=%b lv=%b want 1 2 0 0",
                     exc, exc_code, dmem_req, load_valid);
         end
      end
      @(posedge clk); #1;
      vectors++;
      if (load_valid !== 1'b0 || exc !== 1'b0 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_return: lv=%b exc=%b stall=%b want 0 0 0", load_valid, exc, stall);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n = 1'b0; issue_valid = 1'b0; mem_rw = 1'b0; type_sel = 3'd0;
      addr = '0; wdata = '0; dmem_ready = 1'b0; dmem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall, load_data, load_valid, exc, exc_code} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: req=%b be=%h ld=%h lv=%b exc=%b want all 0",
                  dmem_req, dmem_be, load_data, load_valid, exc);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed_lw;
      run_txn(1'b0, 3'd2, 64'h1004, 64'h0, 64'h8000_0000_0000_0000, 0, 1'b0);
      vectors++;
      if (load_data !== 64'hFFFF_FFFF_8000_0000) begin
         miscompares++; $display("FAIL lw_sext: got %h want ffffffff80000000", load_data);
      end
   endtask

   task automatic test_directed_sb;
      run_txn(1'b1, 3'd0, 64'h1003, 64'hAB, 64'h0, 1, 1'b0);
      vectors++;
      if (cap_be !== 8'h08 || cap_wdata !== 64'hAB00_0000 || cap_addr !== 64'h1000 || cap_we !== 1'b1) begin
         miscompares++;
         $display("FAIL sb_lanes: be=%h wd=%h addr=%h we=%b want 08 ab000000 1000 1",
                  cap_be, cap_wdata, cap_addr, cap_we);
      end
   endtask

   task automatic test_misaligned_ld;
      run_txn(1'b0, 3'd3, 64'h1004, 64'h0, 64'h0, 0, 1'b0);
   endtask

   task automatic test_timeout;
      run_txn(1'b0, 3'd4, 64'h41, 64'h0, 64'h1234_5678_9ABC_DEF0, TO, 1'b0);
      run_txn(1'b0, 3'd4, 64'h41, 64'h0, 64'h1234_5678_9ABC_DEF0, TO - 1, 1'b0);
      vectors++;
      if (load_data !== 64'hDE) begin
         miscompares++; $display("FAIL lbu_late: got %h want de", load_data);
      end
   endtask

   task automatic test_back_to_back;
      run_txn(1'b1, 3'd4, 64'h10, 64'h55, 64'h0, 0, 1'b0);
      run_txn(1'b0, 3'd5, 64'h2, 64'h0, 64'hFFFF_0000, 0, 1'b0);
      vectors++;
      if (load_data !== 64'hFFFF) begin
         miscompares++; $display("FAIL lhu_zext: got %h want ffff", load_data);
      end
   endtask

   task automatic test_reset_mid_req;
      issue_valid = 1'b1; mem_rw = 1'b0; type_sel = 3'd4; addr = 64'h5; dmem_ready = 1'b0;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (dmem_req !== 1'b1) begin
         miscompares++; $display("FAIL rst_pre_req: got %b want 1", dmem_req);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (dmem_req !== 1'b0 || stall !== 1'b0 || dmem_be !== 8'h0 || load_data !== '0) begin
         miscompares++;
         $display("FAIL rst_mid_req: req=%b stall=%b be=%h ld=%h want 0 0 0 0",
                  dmem_req, stall, dmem_be, load_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         vectors++;
         if (load_valid !== 1'b0 || exc !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after: cycle %0d lv=%b exc=%b req=%b stall=%b want 0", c,
                     load_valid, exc, dmem_req, stall);
         end
      end
      run_txn(1'b0, 3'd1, 64'h6, 64'h0, 64'h8001_0000_0000_0000, 0, 1'b0);
   endtask

   task automatic test_random;
      logic       rw;
      logic [2:0] f3;
      logic [63:0] a;
      for (int n = 0; n < 80; n++) begin
         rw = 1'($urandom);
         f3 = 3'($urandom_range(7));
         a  = {$urandom, $urandom};
         if ($urandom_range(3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
         run_txn(rw, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                 int'($urandom_range(4)), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_directed_lw();
      test_directed_sb();
      test_misaligned_ld();
      test_timeout();
      run_txn(1'b1, 3'd4, 64'h0, 64'h0, 64'h0, 0, 1'b0);
      test_back_to_back();
      test_reset_mid_req();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
